router_pkt_rx: RTL and testbench

ROUTER_PKT_RX -- requirements
Module: router_pkt_rx

---
 rtl/router_pkg.sv | 30 +++
 rtl/router_rx_skid.sv | 65 ++++++
 rtl/router_pkt_rx.sv | 201 ++++++++++++++++++++
 tb/tb_router_pkt_rx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet receiver.
// Holds the byte/field widths, the header field positions and the receive FSM
// state encoding, plus helpers that pull the fields out of a header byte.
package router_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 6;
    localparam int unsigned ADDR_W = 2;

    // Header byte layout: {len[7:2], addr[1:0]}
    localparam int unsigned HDR_ADDR_LSB = 0;
    localparam int unsigned HDR_LEN_LSB  = ADDR_W;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StHdr  = 3'd1,
        StPld  = 3'd2,
        StPar  = 3'd3,
        StDone = 3'd4
    } rx_state_e;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[HDR_LEN_LSB +: LEN_W];
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
        return hdr[HDR_ADDR_LSB +: ADDR_W];
    endfunction

endpackage

// File: rtl/router_rx_skid.sv
// Two-entry payload buffer between the router read pipeline and downstream.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   push_i, push_data_i,   write one byte plus its last-of-packet flag
//   push_last_i
//   pop_i                  consume the head entry (ignored when empty)
//   occupancy_o            number of stored entries (0..2)
//   valid_o, data_o,       head entry
//   last_o
module router_rx_skid
    import router_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              push_last_i,
    input  logic              pop_i,
    output logic [1:0]        occupancy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o
);

    logic [DATA_W:0] mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      count_q;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop_i & (count_q != 2'd0);
    // The reader never issues more reads than there is room for, so a push
    // into a full buffer only happens alongside a pop.
    assign do_push = push_i & ((count_q != 2'd2) | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign occupancy_o = count_q;
    assign valid_o     = (count_q != 2'd0);
    assign data_o      = mem_q[rd_ptr_q][DATA_W-1:0];
    assign last_o      = mem_q[rd_ptr_q][DATA_W];

endmodule

// File: rtl/router_pkt_rx.sv
// Router packet receiver: drains the router output FIFO, parses
// {header, payload..., parity} packets and forwards payload bytes downstream.
// Ports:
//   clock, resetn          clock, asynchronous active-low reset
//   vld_out, data_out      router FIFO non-empty / byte (valid cycle after read)
//   read_enb               read strobe to router FIFO
//   pkt_ready              downstream accepts pkt_data
//   pkt_data, pkt_data_valid, pkt_data_last   payload stream
//   pkt_done, parity_err   one-cycle completion pulse and its parity status
//   pkt_len, pkt_addr      fields of the most recent header
//   pkt_count, err_count   completed-packet and parity-error counters
//   stall_timeout          router FIFO has data but reads are starved
module router_pkt_rx
    import router_pkg::*;
#(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              vld_out,
    input  logic [DATA_W-1:0] data_out,
    output logic              read_enb,
    input  logic              pkt_ready,
    output logic [DATA_W-1:0] pkt_data,
    output logic              pkt_data_valid,
    output logic              pkt_data_last,
    output logic              pkt_done,
    output logic              parity_err,
    output logic [LEN_W-1:0]  pkt_len,
    output logic [ADDR_W-1:0] pkt_addr,
    output logic [15:0]       pkt_count,
    output logic [7:0]        err_count,
    output logic              stall_timeout
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] StallMax = CntW'(TIMEOUT - 1);

    rx_state_e         state_q, state_d;
    logic              inflight_q;
    logic [LEN_W:0]    rd_cnt_q, rd_cnt_d;
    logic [LEN_W:0]    bytes_exp;
    logic [LEN_W-1:0]  pld_idx_q, pld_idx_d;
    logic [DATA_W-1:0] par_q, par_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       pkt_count_q;
    logic [7:0]        err_count_q;
    logic [CntW-1:0]   stall_cnt_q;
    logic              stall_q;
    logic              stall_cond;
    logic              hdr_seen;
    logic              hdr_cap;
    logic              pld_last;
    logic              push;
    logic              push_last;
    logic [1:0]        occupancy;
    logic              room;

    // Until the header is in, only the header read may be issued; afterwards
    // the whole packet (header + len payload + parity) is known.
    assign hdr_seen  = state_q inside {StPld, StPar, StDone};
    assign bytes_exp = hdr_seen ? ({1'b0, len_q} + (LEN_W + 1)'(2)) : (LEN_W + 1)'(1);
    // Every read in flight must have a buffer slot waiting for it.
    assign room      = (occupancy + {1'b0, inflight_q}) < 2'd2;
    assign read_enb  = resetn & vld_out & (rd_cnt_q < bytes_exp) & room;
    assign pld_last  = (pld_idx_q == len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q + {{LEN_W{1'b0}}, read_enb};
        pld_idx_d = pld_idx_q;
        par_d     = par_q;
        err_d     = err_q;
        hdr_cap   = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
        case (state_q)
            StIdle: begin
                if (vld_out) begin
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (inflight_q) begin
                    hdr_cap   = 1'b1;
                    par_d     = data_out;
                    pld_idx_d = '0;
                    state_d   = (hdr_len(data_out) == '0) ? StPar : StPld;
                end
            end
            StPld: begin
                if (inflight_q) begin
                    push      = 1'b1;
                    push_last = pld_last;
                    par_d     = par_q ^ data_out;
                    pld_idx_d = pld_idx_q + LEN_W'(1);
                    if (pld_last) begin
                        state_d = StPar;
                    end
                end
            end
            StPar: begin
                if (inflight_q) begin
                    err_d   = (par_q != data_out);
                    state_d = StDone;
                end
            end
            StDone: begin
                // All len+2 reads are already issued, so none happen here and
                // the counter can restart for the next packet.
                state_d  = StIdle;
                rd_cnt_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            inflight_q <= 1'b0;
            rd_cnt_q   <= '0;
            pld_idx_q  <= '0;
            par_q      <= '0;
            err_q      <= 1'b0;
            len_q      <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= read_enb;
            rd_cnt_q   <= rd_cnt_d;
            pld_idx_q  <= pld_idx_d;
            par_q      <= par_d;
            err_q      <= err_d;
            if (hdr_cap) begin
                len_q  <= hdr_len(data_out);
                addr_q <= hdr_addr(data_out);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else if (state_q == StDone) begin
            pkt_count_q <= pkt_count_q + 16'd1;
            if (err_q && (err_count_q != 8'hff)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // stall_cnt_q holds the number of earlier consecutive starved cycles, so
    // the flag shows in the TIMEOUT-th cycle and is then held until a read.
    assign stall_cond = resetn & vld_out & ~read_enb;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else if (read_enb) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else if (stall_cond) begin
            if (stall_cnt_q != StallMax) begin
                stall_cnt_q <= stall_cnt_q + CntW'(1);
            end else begin
                stall_q <= 1'b1;
            end
        end else begin
            stall_cnt_q <= '0;
        end
    end

    router_rx_skid u_skid (
        .clk_i       (clock),
        .rst_ni      (resetn),
        .push_i      (push),
        .push_data_i (data_out),
        .push_last_i (push_last),
        .pop_i       (pkt_ready),
        .occupancy_o (occupancy),
        .valid_o     (pkt_data_valid),
        .data_o      (pkt_data),
        .last_o      (pkt_data_last)
    );

    assign pkt_done      = (state_q == StDone);
    assign parity_err    = (state_q == StDone) & err_q;
    assign pkt_len       = len_q;
    assign pkt_addr      = addr_q;
    assign pkt_count     = pkt_count_q;
    assign err_count     = err_count_q;
    assign stall_timeout = stall_q | (stall_cond & (stall_cnt_q == StallMax));

endmodule

// File: tb/tb_router_pkt_rx.sv
module tb_router_pkt_rx;

    logic        clock = 1'b0;
    logic        resetn;
    logic        vld_out;
    logic [7:0]  data_out;
    logic        read_enb;
    logic        pkt_ready;
    logic [7:0]  pkt_data;
    logic        pkt_data_valid;
    logic        pkt_data_last;
    logic        pkt_done;
    logic        parity_err;
    logic [5:0]  pkt_len;
    logic [1:0]  pkt_addr;
    logic [15:0] pkt_count;
    logic [7:0]  err_count;
    logic        stall_timeout;

    int n_vec = 0;
    int n_bad = 0;
    int done_seen = 0;
    int rd_total = 0;

    logic [7:0] src_q[$];   // router FIFO contents
    logic [8:0] exp_q[$];   // {last, data} expected payload beats
    logic [8:0] done_q[$];  // {parity_err, len, addr} expected completions

    router_pkt_rx #(.TIMEOUT(30)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .vld_out        (vld_out),
        .data_out       (data_out),
        .read_enb       (read_enb),
        .pkt_ready      (pkt_ready),
        .pkt_data       (pkt_data),
        .pkt_data_valid (pkt_data_valid),
        .pkt_data_last  (pkt_data_last),
        .pkt_done       (pkt_done),
        .parity_err     (parity_err),
        .pkt_len        (pkt_len),
        .pkt_addr       (pkt_addr),
        .pkt_count      (pkt_count),
        .err_count      (err_count),
        .stall_timeout  (stall_timeout)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic send_pkt(input int len, input int addr, input bit corrupt);
        logic [7:0] hdr;
        logic [7:0] b;
        logic [7:0] p;
        hdr = {len[5:0], addr[1:0]};
        p = hdr;
        src_q.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            p = p ^ b;
            src_q.push_back(b);
            exp_q.push_back({(i == len - 1), b});
        end
        src_q.push_back(p ^ {7'd0, corrupt});
        done_q.push_back({corrupt, len[5:0], addr[1:0]});
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 600 && done_seen < target; i++) @(negedge clock);
        check("pkt_done count", 32'(done_seen), 32'(target));
        @(negedge clock);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(negedge clock);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_pkt(input int len, input int addr, input bit corrupt);
        int start;
        int target;
        start  = rd_total;
        target = done_seen + 1;
        send_pkt(len, addr, corrupt);
        wait_done(target);
        wait_drain();
        check("reads per packet", 32'(rd_total - start), 32'(len + 2));
    endtask

    // Router FIFO model: a read seen in cycle N presents its byte in N+1.
    initial begin : feeder
        bit rd_pending;
        forever begin
            @(negedge clock);
            rd_pending = read_enb && vld_out;
            if (rd_pending) rd_total++;
            @(posedge clock);
            #1;
            if (rd_pending && src_q.size() > 0) data_out = src_q.pop_front();
            vld_out = (src_q.size() != 0);
        end
    end

    initial begin : beat_monitor
        logic [8:0] e;
        forever begin
            @(negedge clock);
            if (resetn && pkt_data_valid && pkt_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat with empty scoreboard", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("payload beat {last,data}", 32'({pkt_data_last, pkt_data}), 32'(e));
                end
            end
        end
    end

    initial begin : done_monitor
        logic [8:0] e;
        forever begin
            @(negedge clock);
            if (resetn && pkt_done) begin
                done_seen++;
                if (done_q.size() == 0) begin
                    check("pkt_done with empty scoreboard", 32'(done_q.size()), 32'd1);
                end else begin
                    e = done_q.pop_front();
                    check("done {parity_err,len,addr}",
                          32'({parity_err, pkt_len, pkt_addr}), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int  start;
        int  target;
        int  k;
        bit  found;
        bit  got;
        resetn    = 1'b0;
        vld_out   = 1'b0;
        data_out  = 8'd0;
        pkt_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset read_enb", 32'(read_enb), 32'd0);
        check("reset pkt_data_valid", 32'(pkt_data_valid), 32'd0);
        check("reset pkt_done", 32'(pkt_done), 32'd0);
        check("reset pkt_count", 32'(pkt_count), 32'd0);
        check("reset stall_timeout", 32'(stall_timeout), 32'd0);
        @(posedge clock);
        #3 resetn = 1'b1;

        // len=17 addr=0, good parity, always ready
        @(posedge clock);
        #1 pkt_ready = 1'b1;
        run_pkt(17, 0, 1'b0);
        check("pkt_len after len17", 32'(pkt_len), 32'd17);
        check("pkt_count after 1", 32'(pkt_count), 32'd1);
        check("err_count after good", 32'(err_count), 32'd0);

        // len=5 with corrupted parity
        run_pkt(5, 1, 1'b1);
        check("err_count after bad parity", 32'(err_count), 32'd1);
        check("pkt_count after 2", 32'(pkt_count), 32'd2);

        // len=0 addr=2: header + parity only
        run_pkt(0, 2, 1'b0);
        check("pkt_addr after len0", 32'(pkt_addr), 32'd2);
        check("pkt_len after len0", 32'(pkt_len), 32'd0);
        check("pkt_count after 3", 32'(pkt_count), 32'd3);

        // len=20 with 10 cycles of backpressure mid-payload
        start  = rd_total;
        target = done_seen + 1;
        send_pkt(20, 3, 1'b0);
        for (int i = 0; i < 300 && exp_q.size() > 15; i++) @(negedge clock);
        check("mid-payload reached", 32'(exp_q.size() <= 15), 32'd1);
        @(posedge clock);
        #1 pkt_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            if (j >= 2) check("read_enb low under backpressure", 32'(read_enb), 32'd0);
        end
        @(posedge clock);
        #1 pkt_ready = 1'b1;
        wait_done(target);
        wait_drain();
        check("reads per packet len20", 32'(rd_total - start), 32'd22);

        // Starvation: buffer full, router has data
        @(posedge clock);
        #1 pkt_ready = 1'b0;
        target = done_seen + 1;
        send_pkt(10, 1, 1'b0);
        k = 0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clock);
            k = (vld_out && !read_enb) ? k + 1 : 0;
            if (k == 29) check("stall_timeout at cycle 29", 32'(stall_timeout), 32'd0);
            if (k == 30) begin
                check("stall_timeout at cycle 30", 32'(stall_timeout), 32'd1);
                found = 1'b1;
            end
        end
        check("starvation window reached", 32'(found), 32'd1);
        @(posedge clock);
        #1 pkt_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (read_enb) got = 1'b1;
        end
        check("read after release", 32'(got), 32'd1);
        @(negedge clock);
        check("stall_timeout cleared", 32'(stall_timeout), 32'd0);
        wait_done(target);
        wait_drain();
        check("pkt_count after 5", 32'(pkt_count), 32'd5);

        // Reset during payload byte 8 of a len=17 packet
        send_pkt(17, 0, 1'b0);
        for (int i = 0; i < 300 && exp_q.size() > 10; i++) @(negedge clock);
        check("payload byte 8 reached", 32'(exp_q.size() <= 10), 32'd1);
        @(posedge clock);
        #3 resetn = 1'b0;
        src_q.delete();
        exp_q.delete();
        done_q.delete();
        #1;
        check("mid-reset read_enb", 32'(read_enb), 32'd0);
        check("mid-reset pkt_data_valid", 32'(pkt_data_valid), 32'd0);
        check("mid-reset pkt_data", 32'(pkt_data), 32'd0);
        check("mid-reset pkt_count", 32'(pkt_count), 32'd0);
        check("mid-reset pkt_len", 32'(pkt_len), 32'd0);
        check("mid-reset err_count", 32'(err_count), 32'd0);
        repeat (3) @(posedge clock);
        #3 resetn = 1'b1;
        run_pkt(3, 3, 1'b0);
        check("pkt_count after reset", 32'(pkt_count), 32'd1);
        check("pkt_len after reset", 32'(pkt_len), 32'd3);
        check("pkt_addr after reset", 32'(pkt_addr), 32'd3);
        check("err_count after reset", 32'(err_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
